// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: holds the PC during an outstanding imem request,
// buffers the returned instruction for decode and applies branch redirects.
module fetch_ctrl #(
  parameter int unsigned N  = 64,
  parameter int unsigned IW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          br_req_E,
  input  logic [N-1:0]  br_target_E,
  input  logic          stall_D,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic          imem_req,
  output logic          PCSrc_F,
  output logic          pc_en_F,
  output logic [N-1:0]  PCBranch_F,
  output logic [IW-1:0] instr_D,
  output logic          instr_valid_D
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          pend_vld, pend_vld_nxt;
  logic [N-1:0]  pend_tgt, pend_tgt_nxt;
  logic [IW-1:0] instr_nxt;
  logic          valid_nxt;
  logic          pending;

  assign pending    = pend_vld | br_req_E;
  assign PCBranch_F = pend_vld ? pend_tgt : br_target_E;

  // State and buffered-instruction registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      pend_vld      <= 1'b0;
      pend_tgt      <= '0;
      instr_D       <= '0;
      instr_valid_D <= 1'b0;
    end else begin
      state         <= state_nxt;
      pend_vld      <= pend_vld_nxt;
      pend_tgt      <= pend_tgt_nxt;
      instr_D       <= instr_nxt;
      instr_valid_D <= valid_nxt;
    end
  end

  // Next-state, PC control and buffer updates
  always_comb begin
    state_nxt    = state;
    pend_vld_nxt = pend_vld;
    pend_tgt_nxt = pend_tgt;
    instr_nxt    = instr_D;
    valid_nxt    = instr_valid_D;
    imem_req     = 1'b0;
    pc_en_F      = 1'b0;
    PCSrc_F      = 1'b0;

    unique case (state)
      IDLE: begin
        if (br_req_E) begin
          pend_vld_nxt = 1'b1;
          pend_tgt_nxt = br_target_E;
        end
        state_nxt = FETCH;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (!imem_ack) begin
          // Latest redirect wins while the request is outstanding
          if (br_req_E) begin
            pend_vld_nxt = 1'b1;
            pend_tgt_nxt = br_target_E;
          end
        end else if (pending) begin
          pc_en_F      = 1'b1;
          PCSrc_F      = 1'b1;
          pend_vld_nxt = 1'b0;
        end else begin
          pc_en_F   = 1'b1;
          instr_nxt = imem_rdata;
          valid_nxt = 1'b1;
          state_nxt = VALID;
        end
      end

      VALID: begin
        if (br_req_E) begin
          pc_en_F   = 1'b1;
          PCSrc_F   = 1'b1;
          valid_nxt = 1'b0;
          state_nxt = FETCH;
        end else if (!stall_D) begin
          valid_nxt = 1'b0;
          state_nxt = FETCH;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; delivered instructions are checked
// against a queue of expected words filled as acks are driven.
module tb_fetch_ctrl;

  localparam int unsigned N  = 64;
  localparam int unsigned IW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          br_req_E;
  logic [N-1:0]  br_target_E;
  logic          stall_D;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic          imem_req;
  logic          PCSrc_F;
  logic          pc_en_F;
  logic [N-1:0]  PCBranch_F;
  logic [IW-1:0] instr_D;
  logic          instr_valid_D;

  int unsigned   vectors;
  int unsigned   miscompares;
  logic [IW-1:0] exp_q[$];
  logic [IW-1:0] held;

  fetch_ctrl #(.N(N), .IW(IW)) dut (
    .clk          (clk),
    .reset        (reset),
    .br_req_E     (br_req_E),
    .br_target_E  (br_target_E),
    .stall_D      (stall_D),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .imem_req     (imem_req),
    .PCSrc_F      (PCSrc_F),
    .pc_en_F      (pc_en_F),
    .PCBranch_F   (PCBranch_F),
    .instr_D      (instr_D),
    .instr_valid_D(instr_valid_D)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic pop_check(input string tag);
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: observed %h expected <empty queue>", tag, instr_D);
    end else begin
      held = exp_q.pop_front();
      vectors--;
      check(tag, 64'(instr_D), 64'(held));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1; br_req_E = 1'b0; br_target_E = '0; stall_D = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;

    // Reset held for two edges
    cyc();
    check("rst1_req", 64'(imem_req), 64'd0);
    check("rst1_valid", 64'(instr_valid_D), 64'd0);
    check("rst1_pc_en", 64'(pc_en_F), 64'd0);
    cyc();
    check("rst2_req", 64'(imem_req), 64'd0);
    check("rst2_valid", 64'(instr_valid_D), 64'd0);
    reset = 1'b0;
    settle();
    check("idle_req", 64'(imem_req), 64'd0);
    cyc();
    check("first_req", 64'(imem_req), 64'd1);

    // Straight-line fetch, ack every FETCH cycle
    imem_ack = 1'b1; imem_rdata = 32'h8B020020; exp_q.push_back(imem_rdata);
    settle();
    check("sl0_pc_en", 64'(pc_en_F), 64'd1);
    check("sl0_pcsrc", 64'(PCSrc_F), 64'd0);
    cyc();
    imem_ack = 1'b0;
    check("sl0_valid", 64'(instr_valid_D), 64'd1);
    pop_check("sl0_instr");
    settle();
    check("sl0_valid_req", 64'(imem_req), 64'd0);
    check("sl0_valid_pc_en", 64'(pc_en_F), 64'd0);
    cyc();
    check("sl0_consumed", 64'(instr_valid_D), 64'd0);
    imem_ack = 1'b1; imem_rdata = 32'h8B030041; exp_q.push_back(imem_rdata);
    settle();
    check("sl1_pc_en", 64'(pc_en_F), 64'd1);
    check("sl1_pcsrc", 64'(PCSrc_F), 64'd0);
    cyc();
    imem_ack = 1'b0;
    check("sl1_valid", 64'(instr_valid_D), 64'd1);
    pop_check("sl1_instr");
    cyc();
    check("sl1_consumed", 64'(instr_valid_D), 64'd0);

    // Decode back-pressure holds the buffered word
    imem_ack = 1'b1; imem_rdata = 32'hD37FF842; stall_D = 1'b1; exp_q.push_back(imem_rdata);
    cyc();
    imem_ack = 1'b0; imem_rdata = '0;
    check("bp_valid", 64'(instr_valid_D), 64'd1);
    pop_check("bp_instr");
    for (int i = 0; i < 4; i++) begin
      settle();
      check("bp_hold_req", 64'(imem_req), 64'd0);
      check("bp_hold_valid", 64'(instr_valid_D), 64'd1);
      check("bp_hold_instr", 64'(instr_D), 64'(held));
      cyc();
    end
    stall_D = 1'b0;
    settle();
    check("bp_last_req", 64'(imem_req), 64'd0);
    cyc();
    check("bp_resume_req", 64'(imem_req), 64'd1);
    check("bp_resume_valid", 64'(instr_valid_D), 64'd0);

    // Redirects arriving while the ack is delayed
    settle();
    check("pr0_pc_en", 64'(pc_en_F), 64'd0);
    cyc();
    br_req_E = 1'b1; br_target_E = 64'h40;
    settle();
    check("pr1_pc_en", 64'(pc_en_F), 64'd0);
    check("pr1_branch", 64'(PCBranch_F), 64'h40);
    cyc();
    br_target_E = 64'h80;
    settle();
    check("pr2_pc_en", 64'(pc_en_F), 64'd0);
    cyc();
    br_req_E = 1'b0; br_target_E = '0;
    settle();
    check("pr3_pc_en", 64'(pc_en_F), 64'd0);
    check("pr3_branch", 64'(PCBranch_F), 64'h80);
    cyc();
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    settle();
    check("pr_ack_pc_en", 64'(pc_en_F), 64'd1);
    check("pr_ack_pcsrc", 64'(PCSrc_F), 64'd1);
    check("pr_ack_branch", 64'(PCBranch_F), 64'h80);
    cyc();
    imem_ack = 1'b0;
    check("pr_drop_valid", 64'(instr_valid_D), 64'd0);
    check("pr_refetch_req", 64'(imem_req), 64'd1);
    settle();
    check("pr_cleared_branch", 64'(PCBranch_F), 64'h0);

    // Squash in VALID under stall
    imem_ack = 1'b1; imem_rdata = 32'h11111111; stall_D = 1'b1; exp_q.push_back(imem_rdata);
    cyc();
    imem_ack = 1'b0;
    pop_check("sq_instr");
    br_req_E = 1'b1; br_target_E = 64'h100;
    settle();
    check("sq_pc_en", 64'(pc_en_F), 64'd1);
    check("sq_pcsrc", 64'(PCSrc_F), 64'd1);
    check("sq_branch", 64'(PCBranch_F), 64'h100);
    cyc();
    br_req_E = 1'b0; br_target_E = '0; stall_D = 1'b0;
    check("sq_valid", 64'(instr_valid_D), 64'd0);
    check("sq_fetch_req", 64'(imem_req), 64'd1);

    // Ack and redirect in the same FETCH cycle
    imem_ack = 1'b1; br_req_E = 1'b1; br_target_E = 64'h20; imem_rdata = 32'h22222222;
    settle();
    check("same_pc_en", 64'(pc_en_F), 64'd1);
    check("same_pcsrc", 64'(PCSrc_F), 64'd1);
    check("same_branch", 64'(PCBranch_F), 64'h20);
    cyc();
    imem_ack = 1'b0; br_req_E = 1'b0; br_target_E = '0;
    check("same_valid", 64'(instr_valid_D), 64'd0);
    check("same_req", 64'(imem_req), 64'd1);

    // Reset mid-FETCH with a pending redirect and a late ack
    br_req_E = 1'b1; br_target_E = 64'h300;
    cyc();
    br_req_E = 1'b0; br_target_E = '0;
    settle();
    check("rf_pend_branch", 64'(PCBranch_F), 64'h300);
    check("rf_pend_pc_en", 64'(pc_en_F), 64'd0);
    reset = 1'b1;
    cyc();
    imem_ack = 1'b1; imem_rdata = 32'h33333333;
    settle();
    check("rf_req", 64'(imem_req), 64'd0);
    check("rf_pc_en", 64'(pc_en_F), 64'd0);
    check("rf_pcsrc", 64'(PCSrc_F), 64'd0);
    check("rf_valid", 64'(instr_valid_D), 64'd0);
    check("rf_branch", 64'(PCBranch_F), 64'h0);
    reset = 1'b0; imem_ack = 1'b0;
    cyc();
    check("rf_valid_after", 64'(instr_valid_D), 64'd0);
    check("rf_req_after", 64'(imem_req), 64'd1);
    check("rf_branch_after", 64'(PCBranch_F), 64'h0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
